// File: rtl/line_feeder.sv
// line_feeder: credit-gated ready/valid to pixel-strobe feeder for the sharpen top
module line_feeder #(
    parameter int DATA_WIDTH    = 8,
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int NUM_LINE_BUFS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [DATA_WIDTH-1:0]              s_tdata,
    input  logic                               s_tvalid,
    input  logic                               s_tlast,
    output logic                               s_tready,
    output logic [DATA_WIDTH-1:0]              outPixel,
    output logic                               outPixelValid,
    input  logic                               rdBuffEmpty,
    output logic [$clog2(NUM_LINE_BUFS+1)-1:0] credits,
    output logic                               busy,
    output logic                               frameDone,
    output logic                               errTlast,
    output logic                               errCredit
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int KW = $clog2(NUM_LINE_BUFS+1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT_CREDIT, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_mid;
    logic          w_acc;
    logic          w_eol;
    logic          w_eof;
    logic          w_take;

    assign s_tready = (r_state == FEED) && (r_mid || credits != '0);
    assign busy     = (r_state == FEED) || (r_state == WAIT_CREDIT);
    assign w_acc    = s_tvalid && s_tready;
    assign w_eol    = r_col == CW'(IMG_WIDTH-1);
    assign w_eof    = w_eol && r_row == RW'(IMG_HEIGHT-1);
    assign w_take   = w_acc && r_col == '0;

    // pixel forwarding, credit accounting, line/frame counting and the frame FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            credits       <= KW'(NUM_LINE_BUFS);
            r_col         <= '0;
            r_row         <= '0;
            r_mid         <= 1'b0;
            outPixel      <= '0;
            outPixelValid <= 1'b0;
            frameDone     <= 1'b0;
            errTlast      <= 1'b0;
            errCredit     <= 1'b0;
        end else begin
            outPixelValid <= w_acc;
            frameDone     <= 1'b0;
            if (w_acc)
                outPixel <= s_tdata;
            if (rdBuffEmpty && !w_take) begin
                if (credits == KW'(NUM_LINE_BUFS))
                    errCredit <= 1'b1;
                else
                    credits <= credits + KW'(1);
            end else if (w_take && !rdBuffEmpty) begin
                credits <= credits - KW'(1);
            end
            if (w_acc) begin
                if (s_tlast != w_eol)
                    errTlast <= 1'b1;
                r_col <= w_eol ? '0 : r_col + CW'(1);
                r_mid <= !w_eol;
                if (w_eol)
                    r_row <= w_eof ? '0 : r_row + RW'(1);
            end
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= FEED;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_mid   <= 1'b0;
                    end
                end
                FEED: begin
                    if (w_acc && w_eof) begin
                        r_state   <= DONE;
                        frameDone <= 1'b1;
                    end else if (!r_mid && r_col == '0 && credits == '0 && !rdBuffEmpty) begin
                        r_state <= WAIT_CREDIT;
                    end
                end
                WAIT_CREDIT: begin
                    if (credits != '0 || rdBuffEmpty)
                        r_state <= FEED;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_feeder.sv
// tb_line_feeder: directed checks of credits, stalls, tlast, backpressure and reset
module tb_line_feeder;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 6;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] outPixel;
    logic          outPixelValid;
    logic          rdBuffEmpty = 1'b0;
    logic [2:0]    credits;
    logic          busy;
    logic          frameDone;
    logic          errTlast;
    logic          errCredit;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int bad_k = -1;
    int opv_cnt = 0;

    line_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LINE_BUFS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .outPixel(outPixel), .outPixelValid(outPixelValid),
        .rdBuffEmpty(rdBuffEmpty), .credits(credits), .busy(busy), .frameDone(frameDone),
        .errTlast(errTlast), .errCredit(errCredit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive n cycles of beats k, k+1, ...; toggle=1 offers a beat only on even cycles
    task automatic feed(input int n, input bit toggle);
        logic acc;
        for (int i = 0; i < n; i++) begin
            s_tvalid = toggle ? (i % 2 == 0) : 1'b1;
            s_tdata  = 8'hA0 + 8'(k);
            s_tlast  = (k % W == W-1) || (k == bad_k);
            acc      = s_tvalid && s_tready;
            tick();
            chk("opv", {31'd0, outPixelValid}, {31'd0, acc});
            if (outPixelValid) opv_cnt++;
            if (acc) begin
                chk("opix", {24'd0, outPixel}, {24'd0, 8'hA0 + 8'(k)});
                k++;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_credits", credits, 4);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_opv", outPixelValid, 0);
        chk("rst_opix", outPixel, 0);
        chk("rst_done", frameDone, 0);
        chk("rst_errs", {errTlast, errCredit}, 0);
        rst = 1'b1;
        tick();
        rdBuffEmpty = 1'b1;
        tick();
        rdBuffEmpty = 1'b0;
        chk("ovf_credits", credits, 4);
        chk("ovf_err", errCredit, 1);
        repeat (3) tick();
        chk("ovf_sticky", errCredit, 1);
        rst = 1'b0;
        #1;
        chk("ovf_cleared", errCredit, 0);
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_tready", s_tready, 1);
        chk("start_credits", credits, 4);
        k = 0;
        opv_cnt = 0;
        bad_k = 6;
        feed(1, 0);
        chk("cred_3", credits, 3);
        feed(4, 0);
        chk("cred_2", credits, 2);
        feed(1, 0);
        chk("tlast_ok", errTlast, 0);
        feed(1, 0);
        chk("tlast_err", errTlast, 1);
        feed(4, 0);
        chk("cred_1", credits, 1);
        chk("beats_11", k, 11);
        feed(10, 0);
        chk("stall_beats", k, 16);
        chk("stall_opv_cnt", opv_cnt, 16);
        chk("stall_credits", credits, 0);
        chk("stall_tready", s_tready, 0);
        chk("stall_busy", busy, 1);
        chk("stall_opv", outPixelValid, 0);
        rdBuffEmpty = 1'b1;
        tick();
        rdBuffEmpty = 1'b0;
        chk("rel_credits", credits, 1);
        chk("rel_tready", s_tready, 1);
        feed(6, 0);
        chk("rel_beats", k, 20);
        chk("rel_credits0", credits, 0);
        chk("rel_tready0", s_tready, 0);
        rdBuffEmpty = 1'b1;
        tick();
        rdBuffEmpty = 1'b0;
        chk("rel2_credits", credits, 1);
        feed(4, 0);
        chk("frame_beats", k, 24);
        chk("frame_done", frameDone, 1);
        chk("done_tready", s_tready, 0);
        chk("done_busy", busy, 0);
        chk("done_errcredit", errCredit, 0);
        tick();
        chk("done_pulse", frameDone, 0);
        chk("done_hold_tready", s_tready, 0);
        rdBuffEmpty = 1'b1;
        tick();
        rdBuffEmpty = 1'b0;
        chk("f2_credits", credits, 1);
        chk("f2_errcredit", errCredit, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f2_busy", busy, 1);
        chk("tlast_sticky", errTlast, 1);
        k = 0;
        bad_k = -1;
        rdBuffEmpty = 1'b1;
        feed(1, 0);
        rdBuffEmpty = 1'b0;
        chk("simul_credits", credits, 1);
        feed(3, 0);
        chk("simul_tready", s_tready, 1);
        feed(1, 0);
        chk("simul_beats", k, 5);
        chk("simul_credits0", credits, 0);
        feed(6, 1);
        chk("bp_beats", k, 8);
        chk("bp_hold", outPixel, 8'hA7);
        chk("bp_credits", credits, 0);
        rdBuffEmpty = 1'b1;
        tick();
        rdBuffEmpty = 1'b0;
        feed(2, 0);
        chk("pre_rst_opv", outPixelValid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_opv", outPixelValid, 0);
        chk("arst_opix", outPixel, 0);
        chk("arst_credits", credits, 4);
        chk("arst_tready", s_tready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_errs", {errTlast, errCredit}, 0);
        chk("arst_done", frameDone, 0);
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        feed(1, 0);
        chk("post_rst_credits", credits, 3);
        chk("post_rst_errtlast", errTlast, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Upstream stage of the 3x3 sharpen top; converts a ready/valid pixel stream into the top's inPixel/inPixelValid write interface.
- Enforces line-buffer flow control with credits. The top has NUM_LINE_BUFS line buffers and pulses rdBuffEmpty each time it frees one.
- A line may only start being written when a free buffer credit exists.
- Counts columns and rows, checks tlast alignment and flags frame completion.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- NUM_LINE_BUFS, 4, line buffers downstream; also the initial credit count.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a frame when in IDLE or DONE.
- s_tdata  input  DATA_WIDTH  upstream pixel.
- s_tvalid  input  1  upstream pixel valid.
- s_tlast  input  1  upstream end-of-line marker.
- s_tready  output  1  feeder accepts the pixel this cycle.
- outPixel  output  DATA_WIDTH  pixel to the sharpen top.
- outPixelValid  output  1  one-cycle strobe per pixel to the sharpen top.
- rdBuffEmpty  input  1  pulse from the sharpen top; one line buffer freed.
- credits  output  $clog2(NUM_LINE_BUFS+1)  free line buffers available.
- busy  output  1  state is FEED or WAIT_CREDIT.
- frameDone  output  1  one-cycle pulse after the last pixel of the frame is accepted.
- errTlast  output  1  sticky tlast misalignment flag.
- errCredit  output  1  sticky credit overflow flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, credits=NUM_LINE_BUFS.
  - col=0, row=0, midLine=0.
  - outPixel=0, outPixelValid=0, s_tready=0, frameDone=0, errTlast=0, errCredit=0.
  - Reset mid-frame discards all progress; no partial-line recovery.
- Accept: a beat is accepted when s_tvalid && s_tready.
  - outPixel<=s_tdata and outPixelValid<=1 on the next edge (1-cycle latency).
  - Otherwise outPixelValid<=0; outPixel holds its value.
- s_tready is combinational from registered state: (state==FEED) && (midLine || credits!=0).
- Credit rules:
  - The first beat of a line (col==0) consumes one credit and sets midLine.
  - Each rdBuffEmpty pulse returns one credit.
  - Consume and return in the same cycle: credits unchanged.
  - Return while credits==NUM_LINE_BUFS: credits stays saturated and errCredit<=1.
  - Credits never underflow, because s_tready gates consumption.
- Column and row counting:
  - col increments per accepted beat.
  - At col==IMG_WIDTH-1: col<=0, midLine<=0, row increments.
  - At row==IMG_HEIGHT-1 with col==IMG_WIDTH-1: row<=0.
- tlast check:
  - Error when s_tlast=1 on an accepted beat with col!=IMG_WIDTH-1.
  - Error when s_tlast=0 on an accepted beat with col==IMG_WIDTH-1.
  - Either case sets errTlast<=1 (sticky until reset). The counters alone define line boundaries.
- FSM:
  - IDLE: s_tready=0. On start -> FEED, with row=col=0. Credits are not reloaded, because the downstream buffer occupancy persists.
  - FEED:
    - Last beat of the frame accepted -> DONE; frameDone<=1 for one cycle.
    - Line boundary (col==0, not midLine) with credits==0 and no rdBuffEmpty this cycle -> WAIT_CREDIT.
  - WAIT_CREDIT: s_tready=0. When credits!=0 or rdBuffEmpty=1 -> FEED.
  - DONE: s_tready=0. On start -> FEED with a new frame. start in any other state is ignored.
- busy=1 in FEED and WAIT_CREDIT.
- Widths:
  - col is $clog2(IMG_WIDTH) bits.
  - row is $clog2(IMG_HEIGHT) bits.
  - credits is $clog2(NUM_LINE_BUFS+1) bits, so that the value NUM_LINE_BUFS is representable.

Test Plan:
- Credit stall (IMG_WIDTH=4, IMG_HEIGHT=6, NUM_LINE_BUFS=4):
  - Stimulus: reset, start, s_tvalid held at 1.
  - Required: 16 beats accepted, credits steps 4->3->2->1->0, s_tready=0 from the 17th beat, state=WAIT_CREDIT, outPixelValid count=16.
- Credit release:
  - Stimulus: from the stall, one rdBuffEmpty pulse.
  - Required: credits=1, then 4 beats accepted, credits=0 again.
  - The frame completes after 2 pulses total: frameDone one pulse after beat 24, state=DONE, s_tready=0.
- Simultaneous events:
  - Stimulus: rdBuffEmpty asserted on the same cycle as the first beat of a line, with credits=1.
  - Required: credits stays 1, and the next line starts without a WAIT_CREDIT cycle.
- Overflow:
  - Stimulus: rdBuffEmpty pulsed in IDLE with credits=4.
  - Required: credits stays 4, errCredit=1, and it stays 1 until reset.
- tlast error:
  - Stimulus: s_tlast=1 on col 2.
  - Required: errTlast=1, the line still ends at col 3, row increments normally.
- Backpressure and reset:
  - Stimulus: toggle s_tvalid 1010...
  - Required: outPixel equals each accepted s_tdata one cycle later; no dropped or duplicated beat.
  - Stimulus: assert rst mid-line.
  - Required: outputs go immediately (asynchronously) to their reset values and credits=4.
